// File: rtl/axis_stream_fifo.sv
// AXI-Stream FIFO with first-word-fall-through output, occupancy count and almost-full flag.
// All handshake status outputs are registered, so in_ready never depends on out_ready.
module axis_stream_fifo #(
  parameter int DATAW        = 32,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATAW-1:0]           in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATAW-1:0]           out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  typedef struct packed {
    logic             last;
    logic [DATAW-1:0] data;
  } beat_t;

  beat_t         r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_in_ready, r_out_valid, r_afull;

  logic          w_push, w_pop;
  logic [CW-1:0] w_cnt_nxt;
  beat_t         w_rd_beat;

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop)      w_cnt_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_cnt_nxt = r_count - CW'(1);
  end

  // Status flags are precomputed from the next count so they stay pure registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_afull     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count     <= w_cnt_nxt;
      r_in_ready  <= (w_cnt_nxt != DEPTH_C);
      r_out_valid <= (w_cnt_nxt != '0);
      r_afull     <= (w_cnt_nxt >= AFULL_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= '{last: in_last, data: in_data};
  end

  assign w_rd_beat   = r_mem[r_rd_ptr];
  assign out_data    = w_rd_beat.data;
  assign out_last    = w_rd_beat.last;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign count       = r_count;
  assign almost_full = r_afull;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= DEPTH_C);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(w_pop && r_count == '0));

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed bench for axis_stream_fifo (DEPTH=4, DATAW=32) with hand-computed expectations.
module tb_axis_stream_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic        almost_full;

  int n_chk  = 0;
  int n_pass = 0;

  axis_stream_fifo #(.DATAW(32), .DEPTH(4), .AFULL_THRESH(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, rcvd, cyc, maxc;
    bit push, pop;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_afull", 32'(almost_full), 32'd0);

    // single beat
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'hDEADBEEF);
    chk("single_last", 32'(out_last), 32'd1);
    chk("single_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_count", 32'(count), 32'd0);
    chk("single_pop_valid", 32'(out_valid), 32'd0);

    // fill under backpressure
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), (i >= 3) ? 32'd1 : 32'd0);
      chk("fill_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      chk("fill_head", out_data, 32'd1);
    end
    in_data = 32'd5;
    step();
    chk("full_refuse_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("hold_data", out_data, 32'd1);
    chk("hold_valid", 32'(out_valid), 32'd1);

    // full plus pop: pop only, then the pending beat goes in
    out_ready = 1'b1;
    step();
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_in_ready", 32'(in_ready), 32'd1);
    chk("fullpop_head", out_data, 32'd2);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("pending_taken", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("drain_data", out_data, 32'(i));
      chk("drain_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(count), 32'd0);

    // random-gap stream with random backpressure
    sent = 0; rcvd = 0; cyc = 0; maxc = 0;
    while (rcvd < 37 && cyc < 3000) begin
      if (!in_valid && sent < 37 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1; in_data = 32'(sent); in_last = (sent % 8 == 7);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      push = in_valid && in_ready;
      pop  = out_valid && out_ready;
      if (pop) begin
        chk("stream_data", out_data, 32'(rcvd));
        chk("stream_last", 32'(out_last), (rcvd % 8 == 7) ? 32'd1 : 32'd0);
        rcvd++;
      end
      step();
      cyc++;
      if (push) begin
        sent++;
        in_valid = 1'b0; in_last = 1'b0;
      end
      if (int'(count) > maxc) maxc = int'(count);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_done", 32'(rcvd), 32'd37);
    chk("stream_maxcount", (maxc <= 4) ? 32'd1 : 32'd0, 32'd1);

    // both sides ready: one beat per cycle, occupancy stays at 1
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 32'(100 + k);
      if (k > 0) begin
        chk("tput_valid", 32'(out_valid), 32'd1);
        chk("tput_data", out_data, 32'(100 + k - 1));
        chk("tput_count", 32'(count), 32'd1);
      end
      step();
    end
    in_valid = 1'b0;
    chk("tput_last", out_data, 32'd107);
    step();
    out_ready = 1'b0;
    chk("tput_empty", 32'(count), 32'd0);

    // reset mid-stream
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'(200 + i);
      step();
    end
    chk("mid_count", 32'(count), 32'd3);
    rst = 1'b1; out_ready = 1'b1; in_data = 32'hAA;
    step();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", out_data, 32'h55);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
